// File: rtl/tft_timing_pkg.sv
// Timing constants, colour constants and test-pattern helpers shared by the
// 480x272 TFT timing controller. Consumed by tft_ctrl_if and tft_ctrl.
package tft_timing_pkg;

  // Horizontal timing in pixel clocks.
  localparam int H_SYNC  = 41;
  localparam int H_BACK  = 2;
  localparam int H_DISP  = 480;
  localparam int H_FRONT = 2;
  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;

  // Vertical timing in lines.
  localparam int V_SYNC  = 10;
  localparam int V_BACK  = 2;
  localparam int V_DISP  = 272;
  localparam int V_FRONT = 2;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  // Active window: start is inclusive, end is exclusive.
  localparam int H_ACT_START = H_SYNC + H_BACK;
  localparam int H_ACT_END   = H_ACT_START + H_DISP;
  localparam int V_ACT_START = V_SYNC + V_BACK;
  localparam int V_ACT_END   = V_ACT_START + V_DISP;

  // Test pattern bars are this many pixels wide.
  localparam int BAR_WIDTH = 60;

  typedef logic [15:0] rgb565_t;

  // RGB565 colours of the eight test bars.
  localparam rgb565_t COLOR_WHITE   = 16'hFFFF;
  localparam rgb565_t COLOR_YELLOW  = 16'hFFE0;
  localparam rgb565_t COLOR_CYAN    = 16'h07FF;
  localparam rgb565_t COLOR_GREEN   = 16'h07E0;
  localparam rgb565_t COLOR_MAGENTA = 16'hF81F;
  localparam rgb565_t COLOR_RED     = 16'hF800;
  localparam rgb565_t COLOR_BLUE    = 16'h001F;
  localparam rgb565_t COLOR_BLACK   = 16'h0000;

  // Bars listed from the left edge of the screen to the right edge.
  typedef enum logic [2:0] {
    BAR_WHITE, BAR_YELLOW, BAR_CYAN, BAR_GREEN,
    BAR_MAGENTA, BAR_RED, BAR_BLUE, BAR_BLACK
  } bar_e;

  // Map a bar index to its colour.
  function automatic rgb565_t bar_color(input bar_e bar);
    rgb565_t c;
    case (bar)
      BAR_WHITE:   c = COLOR_WHITE;
      BAR_YELLOW:  c = COLOR_YELLOW;
      BAR_CYAN:    c = COLOR_CYAN;
      BAR_GREEN:   c = COLOR_GREEN;
      BAR_MAGENTA: c = COLOR_MAGENTA;
      BAR_RED:     c = COLOR_RED;
      BAR_BLUE:    c = COLOR_BLUE;
      default:     c = COLOR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tft_ctrl_if.sv
// Panel-side bundle of the TFT timing controller: the pixel request/response
// pair toward the image source plus the LCD connector signals.
// The master modport is the controller; the slave modport is the source/panel side.
interface tft_ctrl_if;
  import tft_timing_pkg::*;

  rgb565_t    data_in;
  logic [9:0] hcount;
  logic [9:0] vcount;
  rgb565_t    TFT_RGB;
  logic       TFT_HS;
  logic       TFT_VS;
  logic       TFT_CLK;
  logic       TFT_DE;
  logic       TFT_PWM;

  modport master (
    input  data_in,
    output hcount, vcount, TFT_RGB, TFT_HS, TFT_VS, TFT_CLK, TFT_DE, TFT_PWM
  );

  modport slave (
    output data_in,
    input  hcount, vcount, TFT_RGB, TFT_HS, TFT_VS, TFT_CLK, TFT_DE, TFT_PWM
  );

endinterface

// File: rtl/tft_scan_counter.sv
// Enabled wrap counter: counts 0..MAX-1 while en is high and pulses wrap
// combinationally on the enabled cycle that returns it to 0.
module tft_scan_counter #(
  parameter int MAX   = 525,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  assign wrap = en && (count == WIDTH'(MAX - 1));

  // Advance on enable, fold back to zero at the terminal value.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/tft_ctrl.sv
// RGB565 timing controller for a 480x272 TFT panel running on the 9 MHz
// pixel clock. Scan counters are registered; syncs, DE and the active-area
// coordinates are zero-latency decodes of them, and TFT_RGB is a same-cycle
// gate of the pixel data.
// Build option: define TFT_TEST_PATTERN_EN to replace data_in with eight
// vertical colour bars.
module tft_ctrl #(
  parameter int H_SYNC  = tft_timing_pkg::H_SYNC,
  parameter int H_BACK  = tft_timing_pkg::H_BACK,
  parameter int H_DISP  = tft_timing_pkg::H_DISP,
  parameter int H_FRONT = tft_timing_pkg::H_FRONT,
  parameter int V_SYNC  = tft_timing_pkg::V_SYNC,
  parameter int V_BACK  = tft_timing_pkg::V_BACK,
  parameter int V_DISP  = tft_timing_pkg::V_DISP,
  parameter int V_FRONT = tft_timing_pkg::V_FRONT
) (
  input  logic          Clk9M,
  input  logic          Rst,
  tft_ctrl_if.master    tft
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  localparam logic [9:0] HS_END  = 10'(H_SYNC);
  localparam logic [9:0] VS_END  = 10'(V_SYNC);
  localparam logic [9:0] H_START = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_END   = 10'(H_SYNC + H_BACK + H_DISP);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_END   = 10'(V_SYNC + V_BACK + V_DISP);

  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic       h_wrap;
  logic       unused_v_wrap;
  logic       h_active;
  logic       v_active;
  logic       de;
  logic [9:0] hcount_i;
  logic [9:0] vcount_i;
  logic       pwm_q;
  tft_timing_pkg::rgb565_t pixel;

  tft_scan_counter #(.MAX(H_TOTAL), .WIDTH(10)) u_hcnt (
    .clk   (Clk9M),
    .rst   (Rst),
    .en    (1'b1),
    .count (hcnt),
    .wrap  (h_wrap)
  );

  // The vertical counter steps once per line, on the horizontal wrap.
  tft_scan_counter #(.MAX(V_TOTAL), .WIDTH(10)) u_vcnt (
    .clk   (Clk9M),
    .rst   (Rst),
    .en    (h_wrap),
    .count (vcnt),
    .wrap  (unused_v_wrap)
  );

  assign h_active = (hcnt >= H_START) && (hcnt < H_END);
  assign v_active = (vcnt >= V_START) && (vcnt < V_END);
  assign de       = h_active && v_active;
  assign hcount_i = de ? (hcnt - H_START) : '0;
  assign vcount_i = de ? (vcnt - V_START) : '0;

`ifdef TFT_TEST_PATTERN_EN
  logic unused_data_in;
  assign unused_data_in = ^tft.data_in;
  assign pixel = tft_timing_pkg::bar_color(
                   tft_timing_pkg::bar_e'(3'(hcount_i / 10'(tft_timing_pkg::BAR_WIDTH))));
`else
  assign pixel = tft.data_in;
`endif

  // Backlight comes on the first clock after reset is released.
  always_ff @(posedge Clk9M) begin
    if (Rst) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= 1'b1;
    end
  end

  assign tft.hcount  = hcount_i;
  assign tft.vcount  = vcount_i;
  assign tft.TFT_HS  = (hcnt >= HS_END);
  assign tft.TFT_VS  = (vcnt >= VS_END);
  assign tft.TFT_DE  = de;
  assign tft.TFT_RGB = de ? pixel : '0;
  assign tft.TFT_CLK = Clk9M;
  assign tft.TFT_PWM = pwm_q;

endmodule

// File: tb/tb_tft_ctrl.sv
// Self-checking bench for tft_ctrl. Instance A uses the real 525x286 timing
// up to a mid-frame reset; instance B uses shrunken timing so that several
// whole frames fit in a short run. Expected outputs come from a position
// model computed from the elapsed clock count since reset release.
`timescale 1ns/1ps
module tb_tft_ctrl;

  localparam int CLK_HALF = 5;

  // Real panel timing for instance A.
  localparam int AHS = 41, AHB = 2, AHD = 480, AHF = 2;
  localparam int AVS = 10, AVB = 2, AVD = 272, AVF = 2;
  localparam int AHT = 525;

  // Shrunken timing for instance B: 15 clocks per line, 8 lines per frame.
  localparam int BHS = 3, BHB = 2, BHD = 8, BHF = 2;
  localparam int BVS = 2, BVB = 1, BVD = 4, BVF = 1;
  localparam int BHT = 15;
  localparam int BFRAME = 15 * 8;

  logic Clk9M = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   checks = 0;
  int   errors = 0;

  tft_ctrl_if bus_a();
  tft_ctrl_if bus_b();

  tft_ctrl dut_a (
    .Clk9M (Clk9M),
    .Rst   (rst_a),
    .tft   (bus_a)
  );

  tft_ctrl #(
    .H_SYNC(BHS), .H_BACK(BHB), .H_DISP(BHD), .H_FRONT(BHF),
    .V_SYNC(BVS), .V_BACK(BVB), .V_DISP(BVD), .V_FRONT(BVF)
  ) dut_b (
    .Clk9M (Clk9M),
    .Rst   (rst_b),
    .tft   (bus_b)
  );

  always #CLK_HALF Clk9M = ~Clk9M;

  // Colour of test bar idx, left to right.
  function automatic logic [15:0] bar_ref(input int idx);
    case (idx)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  // Expected {HS, VS, DE, hcount, vcount, RGB} after t clocks since release.
  function automatic logic [38:0] model(input int t,
      input int hsy, input int hbk, input int hdp, input int hfp,
      input int vsy, input int vbk, input int vdp, input int vfp,
      input logic [15:0] din);
    int ht, vt, h, v, hx, vy;
    logic de, hs, vs;
    logic [15:0] rgb;
    ht = hsy + hbk + hdp + hfp;
    vt = vsy + vbk + vdp + vfp;
    h  = t % ht;
    v  = (t / ht) % vt;
    hx = h - hsy - hbk;
    vy = v - vsy - vbk;
    de = (hx >= 0) && (hx < hdp) && (vy >= 0) && (vy < vdp);
    hs = (h >= hsy);
    vs = (v >= vsy);
    if (!de) begin
      hx = 0;
      vy = 0;
    end
`ifdef TFT_TEST_PATTERN_EN
    rgb = de ? bar_ref(hx / 60) : 16'h0000;
`else
    rgb = de ? din : 16'h0000;
`endif
    return {hs, vs, de, 10'(hx), 10'(vy), rgb};
  endfunction

  // One clock: wait past the rising edge so outputs have settled.
  task automatic cyc();
    @(posedge Clk9M);
    #2;
  endtask

  task automatic test_reset();
    logic [38:0] obs;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.data_in = 16'h0000;
    bus_b.data_in = 16'h0000;
    repeat (20) cyc();
    #1;
    obs = {bus_a.TFT_HS, bus_a.TFT_VS, bus_a.TFT_DE, bus_a.hcount, bus_a.vcount, bus_a.TFT_RGB};
    checks++;
    if (obs !== 39'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs_a got %h want %h", obs, 39'd0);
    end
    checks++;
    if (bus_a.TFT_PWM !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_pwm got %b want 0", bus_a.TFT_PWM);
    end
    obs = {bus_b.TFT_HS, bus_b.TFT_VS, bus_b.TFT_DE, bus_b.hcount, bus_b.vcount, bus_b.TFT_RGB};
    checks++;
    if (obs !== 39'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs_b got %h want %h", obs, 39'd0);
    end
    checks++;
    if (bus_a.TFT_CLK !== Clk9M) begin
      errors++;
      $display("[TB] FAIL clk_passthru_high got %b want %b", bus_a.TFT_CLK, Clk9M);
    end
    @(negedge Clk9M);
    #1;
    checks++;
    if (bus_a.TFT_CLK !== Clk9M) begin
      errors++;
      $display("[TB] FAIL clk_passthru_low got %b want %b", bus_a.TFT_CLK, Clk9M);
    end
  endtask

  // First line after release with constant white input.
  task automatic test_line_timing(inout int t);
    logic [38:0] obs, exp;
    int hs_low;
    hs_low = 0;
    cyc();
    #1;
    rst_a = 1'b0;
    bus_a.data_in = 16'hFFFF;
    t = 0;
    for (int i = 0; i < AHT; i++) begin
      cyc();
      t++;
      #1;
      if (i == 0) begin
        checks++;
        if (bus_a.TFT_PWM !== 1'b1) begin
          errors++;
          $display("[TB] FAIL pwm_after_release got %b want 1", bus_a.TFT_PWM);
        end
      end
      exp = model(t, AHS, AHB, AHD, AHF, AVS, AVB, AVD, AVF, 16'hFFFF);
      obs = {bus_a.TFT_HS, bus_a.TFT_VS, bus_a.TFT_DE, bus_a.hcount, bus_a.vcount, bus_a.TFT_RGB};
      checks++;
      if (obs !== exp) begin
        errors++;
        if (errors < 20) $display("[TB] FAIL line_scan t=%0d got %h want %h", t, obs, exp);
      end
      if (bus_a.TFT_HS === 1'b0) hs_low++;
    end
    checks++;
    if (hs_low != AHS) begin
      errors++;
      $display("[TB] FAIL hs_low_width got %0d want %0d", hs_low, AHS);
    end
  endtask

  // Random pixels from line 1 up to line 100, column 200.
  task automatic test_scan_random(inout int t);
    logic [38:0] obs, exp;
    logic [15:0] din;
    int target, de_line12;
    logic prev_vs;
    target = 100 * AHT + 200;
    de_line12 = 0;
    prev_vs = bus_a.TFT_VS;
    while (t < target) begin
      cyc();
      t++;
      din = 16'($urandom);
      bus_a.data_in = din;
      #1;
      exp = model(t, AHS, AHB, AHD, AHF, AVS, AVB, AVD, AVF, din);
      obs = {bus_a.TFT_HS, bus_a.TFT_VS, bus_a.TFT_DE, bus_a.hcount, bus_a.vcount, bus_a.TFT_RGB};
      checks++;
      if (obs !== exp) begin
        errors++;
        if (errors < 20) $display("[TB] FAIL random_scan t=%0d got %h want %h", t, obs, exp);
      end
      if (t == 10 * AHT) begin
        checks++;
        if ({prev_vs, bus_a.TFT_VS} !== 2'b01) begin
          errors++;
          $display("[TB] FAIL vs_rise_point got %b want 01", {prev_vs, bus_a.TFT_VS});
        end
      end
      if (t == 12 * AHT + 43) begin
        checks++;
        if ({bus_a.TFT_DE, bus_a.hcount, bus_a.vcount} !== {1'b1, 10'd0, 10'd0}) begin
          errors++;
          $display("[TB] FAIL first_de got %b/%0d/%0d want 1/0/0",
                   bus_a.TFT_DE, bus_a.hcount, bus_a.vcount);
        end
      end
      if ((t / AHT) == 12 && bus_a.TFT_DE === 1'b1) de_line12++;
      prev_vs = bus_a.TFT_VS;
    end
    checks++;
    if (de_line12 != AHD) begin
      errors++;
      $display("[TB] FAIL de_per_line got %0d want %0d", de_line12, AHD);
    end
  endtask

  // Reset in the middle of line 100, then the frame restarts from sync.
  task automatic test_mid_reset(inout int t);
    logic [38:0] obs, exp;
    logic [15:0] din;
    int vs_low;
    vs_low = 0;
    rst_a = 1'b1;
    bus_a.data_in = 16'hA5A5;
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      obs = {bus_a.TFT_HS, bus_a.TFT_VS, bus_a.TFT_DE, bus_a.hcount, bus_a.vcount, bus_a.TFT_RGB};
      checks++;
      if ({obs, bus_a.TFT_PWM} !== 40'd0) begin
        errors++;
        $display("[TB] FAIL mid_reset_outputs cyc=%0d got %h want 0", i, {obs, bus_a.TFT_PWM});
      end
    end
    rst_a = 1'b0;
    t = 0;
    for (int i = 0; i < 2 * AHT; i++) begin
      cyc();
      t++;
      din = 16'($urandom);
      bus_a.data_in = din;
      #1;
      exp = model(t, AHS, AHB, AHD, AHF, AVS, AVB, AVD, AVF, din);
      obs = {bus_a.TFT_HS, bus_a.TFT_VS, bus_a.TFT_DE, bus_a.hcount, bus_a.vcount, bus_a.TFT_RGB};
      checks++;
      if (obs !== exp) begin
        errors++;
        if (errors < 20) $display("[TB] FAIL restart_scan t=%0d got %h want %h", t, obs, exp);
      end
      if (bus_a.TFT_VS === 1'b0) vs_low++;
    end
    checks++;
    if (vs_low != 2 * AHT) begin
      errors++;
      $display("[TB] FAIL restart_vs_low got %0d want %0d", vs_low, 2 * AHT);
    end
  endtask

  // Three whole frames on the shrunken-timing instance.
  task automatic test_small_frames();
    logic [38:0] obs, exp;
    logic [15:0] din;
    int rise_t[$];
    int de_cnt[3];
    int vs_low[3];
    int last_hc, last_vc, f, t;
    logic prev_vs;
    rst_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      de_cnt[i] = 0;
      vs_low[i] = 0;
    end
    last_hc = -1;
    last_vc = -1;
    rst_b = 1'b0;
    t = 0;
    prev_vs = bus_b.TFT_VS;
    if (bus_b.TFT_VS === 1'b0) vs_low[0]++;
    for (int i = 1; i < 3 * BFRAME; i++) begin
      cyc();
      t++;
      din = 16'($urandom);
      bus_b.data_in = din;
      #1;
      exp = model(t, BHS, BHB, BHD, BHF, BVS, BVB, BVD, BVF, din);
      obs = {bus_b.TFT_HS, bus_b.TFT_VS, bus_b.TFT_DE, bus_b.hcount, bus_b.vcount, bus_b.TFT_RGB};
      checks++;
      if (obs !== exp) begin
        errors++;
        if (errors < 20) $display("[TB] FAIL small_scan t=%0d got %h want %h", t, obs, exp);
      end
      f = t / BFRAME;
      if (bus_b.TFT_DE === 1'b1) begin
        de_cnt[f]++;
        last_hc = int'(bus_b.hcount);
        last_vc = int'(bus_b.vcount);
      end
      if (bus_b.TFT_VS === 1'b0) vs_low[f]++;
      if (prev_vs === 1'b0 && bus_b.TFT_VS === 1'b1) rise_t.push_back(t);
      prev_vs = bus_b.TFT_VS;
    end
    checks++;
    if (rise_t.size() != 3) begin
      errors++;
      $display("[TB] FAIL vs_rise_count got %0d want 3", rise_t.size());
    end else begin
      checks++;
      if (rise_t[0] != BVS * BHT) begin
        errors++;
        $display("[TB] FAIL vs_first_rise got %0d want %0d", rise_t[0], BVS * BHT);
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (rise_t[i] - rise_t[i-1] != BFRAME) begin
          errors++;
          $display("[TB] FAIL vs_period got %0d want %0d", rise_t[i] - rise_t[i-1], BFRAME);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (de_cnt[i] != BHD * BVD) begin
        errors++;
        $display("[TB] FAIL de_per_frame f=%0d got %0d want %0d", i, de_cnt[i], BHD * BVD);
      end
      checks++;
      if (vs_low[i] != BVS * BHT) begin
        errors++;
        $display("[TB] FAIL vs_low_per_frame f=%0d got %0d want %0d", i, vs_low[i], BVS * BHT);
      end
    end
    checks++;
    if (last_hc != BHD - 1 || last_vc != BVD - 1) begin
      errors++;
      $display("[TB] FAIL last_de got %0d/%0d want %0d/%0d", last_hc, last_vc, BHD - 1, BVD - 1);
    end
  endtask

  initial begin
    int t_a;
    t_a = 0;
    test_reset();
    test_line_timing(t_a);
    test_scan_random(t_a);
    test_mid_reset(t_a);
    test_small_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
